// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular sample buffer with pre-trigger history,
// per-bit level/edge trigger with AND/OR combine, and sample-enable decimation.
module la_capture_core #(
  parameter int DATA_W = 8,
  parameter int TRIG_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              clk_rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic              sample_en,
  input  logic              arm,
  input  logic              abort,
  input  logic [TRIG_W-1:0] trig_mask,
  input  logic [TRIG_W-1:0] trig_value,
  input  logic [TRIG_W-1:0] trig_edge_en,
  input  logic              trig_mode,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        state_o,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   start_ptr_q, start_ptr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [TRIG_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                triggered_q, triggered_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [TRIG_W-1:0]   bit_hit;
  logic                trig_hit;
  logic                capturing;
  logic                smp;
  logic                start_cmd;
  logic                pre_last;
  logic                post_last;
  logic [ADDR_W-1:0]   post_len;

  assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign smp       = capturing && sample_en && !abort;
  assign start_cmd = ((state_q == S_IDLE) || (state_q == S_DONE)) && arm && !abort;
  assign pre_last  = (pre_cnt_q + ADDR_W'(1)) == trig_addr_q;
  assign post_last = post_cnt_q == ADDR_W'(1);
  // DEPTH is a power of two, so DEPTH-1-len is the bitwise inverse of len.
  assign post_len  = ~trig_addr_q;

  // Edge bits stay false until a previous sample exists after arm.
  for (genvar gi = 0; gi < TRIG_W; gi++) begin : g_bit
    assign bit_hit[gi] = (trig_i[gi] == trig_value[gi]) &&
                         (!trig_edge_en[gi] || (prev_valid_q && (prev_q[gi] != trig_i[gi])));
  end

  assign trig_hit = trig_mode ? |(bit_hit & trig_mask) : &(bit_hit | ~trig_mask);

  always_ff @(posedge sys_clk or negedge clk_rst_n) begin
    if (!clk_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm) state_d = (pretrig_len == '0) ? S_WAIT : S_PRE;
        S_PRE:          if (smp && pre_last) state_d = S_WAIT;
        S_WAIT:         if (smp && trig_hit) state_d = (post_len == '0) ? S_DONE : S_POST;
        S_POST:         if (smp && post_last) state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    state_o   = state_q;
    triggered = triggered_q;
    done      = done_q;
    trig_addr = trig_addr_q;
    rd_data   = rd_data_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    start_ptr_d  = start_ptr_q;
    trig_addr_d  = trig_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    done_d       = done_q;
    if (abort) begin
      triggered_d = 1'b0;
      done_d      = 1'b0;
    end else if (start_cmd) begin
      // pretrig_len is ADDR_W wide, so it can never exceed DEPTH-1.
      wr_ptr_d     = '0;
      pre_cnt_d    = '0;
      trig_addr_d  = pretrig_len;
      prev_valid_d = 1'b0;
      triggered_d  = 1'b0;
      done_d       = 1'b0;
    end else if (smp) begin
      wr_ptr_d     = wr_ptr_q + ADDR_W'(1);
      prev_d       = trig_i;
      prev_valid_d = 1'b1;
      case (state_q)
        S_PRE: pre_cnt_d = pre_cnt_q + ADDR_W'(1);
        S_WAIT: begin
          if (trig_hit) begin
            start_ptr_d = wr_ptr_q - trig_addr_q;
            post_cnt_d  = post_len;
            triggered_d = 1'b1;
            if (post_len == '0) done_d = 1'b1;
          end
        end
        S_POST: begin
          post_cnt_d = post_cnt_q - ADDR_W'(1);
          if (post_last) done_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge clk_rst_n) begin
    if (!clk_rst_n) begin
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      start_ptr_q  <= '0;
      trig_addr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      start_ptr_q  <= start_ptr_d;
      trig_addr_q  <= trig_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (smp) mem[wr_ptr_q] <= data_i;
  end

  // Logical index 0 maps to the oldest sample of the capture.
  always_ff @(posedge sys_clk or negedge clk_rst_n) begin
    if (!clk_rst_n)  rd_data_q <= '0;
    else if (rd_en)  rd_data_q <= mem[start_ptr_q + rd_addr];
  end

endmodule

// File: tb/tb_la_capture_core.sv
// Directed self-checking bench for la_capture_core (DEPTH=16, DATA_W=8, TRIG_W=4).
module tb_la_capture_core;

  logic       sys_clk = 1'b0;
  logic       clk_rst_n;
  logic [7:0] data_i;
  logic [3:0] trig_i;
  logic       sample_en;
  logic       arm;
  logic       abort;
  logic [3:0] trig_mask;
  logic [3:0] trig_value;
  logic [3:0] trig_edge_en;
  logic       trig_mode;
  logic [3:0] pretrig_len;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [2:0] state_o;
  logic       triggered;
  logic       done;
  logic [3:0] trig_addr;

  int checks   = 0;
  int failures = 0;

  la_capture_core #(.DATA_W(8), .TRIG_W(4), .DEPTH(16)) dut (
    .sys_clk      (sys_clk),
    .clk_rst_n    (clk_rst_n),
    .data_i       (data_i),
    .trig_i       (trig_i),
    .sample_en    (sample_en),
    .arm          (arm),
    .abort        (abort),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .trig_edge_en (trig_edge_en),
    .trig_mode    (trig_mode),
    .pretrig_len  (pretrig_len),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .state_o      (state_o),
    .triggered    (triggered),
    .done         (done),
    .trig_addr    (trig_addr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] m, input logic [3:0] v, input logic [3:0] e, input logic md);
    trig_mask    = m;
    trig_value   = v;
    trig_edge_en = e;
    trig_mode    = md;
  endtask

  task automatic do_arm(input logic [3:0] len);
    arm         = 1'b1;
    pretrig_len = len;
    tick();
    arm = 1'b0;
  endtask

  task automatic smp(input logic [7:0] d, input logic [3:0] t);
    data_i    = d;
    trig_i    = t;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic readout(input string tag, input int base, input int step);
    for (int i = 0; i < 16; i++) begin
      rd_en   = 1'b1;
      rd_addr = i[3:0];
      tick();
      check($sformatf("%s[%0d]", tag, i), 32'(rd_data), (base + step * i) & 255);
    end
    rd_en = 1'b0;
  endtask

  // Level AND capture: trigger on sample 5, readout 1..16; optional arm pulse at arm_at.
  task automatic run_t1(input string tag, input int arm_at);
    cfg(4'b0011, 4'b0001, 4'b0000, 1'b0);
    do_arm(4'd4);
    for (int n = 0; n <= 16; n++) begin
      if (n == arm_at) arm = 1'b1;
      smp(n[7:0], n[3:0]);
      arm = 1'b0;
      if (n == 4)  check({tag, "_pre_trig"}, 32'(triggered), 0);
      if (n == 4)  check({tag, "_wait"}, 32'(state_o), 2);
      if (n == 5)  check({tag, "_trig"}, 32'(triggered), 1);
      if (n == 5)  check({tag, "_post"}, 32'(state_o), 3);
      if (n == 15) check({tag, "_not_done"}, 32'(done), 0);
    end
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_state_done"}, 32'(state_o), 4);
    check({tag, "_trig_addr"}, 32'(trig_addr), 4);
    readout({tag, "_rd"}, 1, 1);
  endtask

  initial begin
    clk_rst_n = 1'b0;
    data_i = '0; trig_i = '0; sample_en = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b0);
    pretrig_len = '0; rd_en = 1'b0; rd_addr = '0;
    #12;
    check("rst_state", 32'(state_o), 0);
    check("rst_trig", 32'(triggered), 0);
    check("rst_done", 32'(done), 0);
    check("rst_taddr", 32'(trig_addr), 0);
    check("rst_rdata", 32'(rd_data), 0);
    @(negedge sys_clk);
    clk_rst_n = 1'b1;
    tick();

    run_t1("lvl", -1);

    // Wraparound: single pulse on bit2 at sample 40.
    cfg(4'b0100, 4'b0100, 4'b0000, 1'b0);
    do_arm(4'd4);
    for (int n = 0; n <= 51; n++) begin
      smp(n[7:0], (n == 40) ? 4'b0100 : 4'b0000);
      if (n == 39) check("wrap_pre_trig", 32'(triggered), 0);
    end
    check("wrap_trig", 32'(triggered), 1);
    check("wrap_done", 32'(done), 1);
    readout("wrap_rd", 36, 1);

    // Falling edge, OR mode, no pre-trigger.
    cfg(4'b0001, 4'b0000, 4'b0001, 1'b1);
    trig_i = 4'b0000;
    do_arm(4'd0);
    for (int n = 0; n <= 24; n++) begin
      smp(n[7:0], (n >= 3 && n <= 8) ? 4'b0001 : 4'b0000);
      if (n == 0) check("fall_first", 32'(triggered), 0);
      if (n == 0) check("fall_wait", 32'(state_o), 2);
      if (n == 8) check("fall_pre_edge", 32'(triggered), 0);
      if (n == 9) check("fall_edge", 32'(triggered), 1);
    end
    check("fall_done", 32'(done), 1);
    check("fall_taddr", 32'(trig_addr), 0);
    readout("fall_rd", 9, 1);

    // Empty mask, AND: forced trigger on first WAIT sample.
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b0);
    do_arm(4'd2);
    for (int n = 0; n <= 15; n++) begin
      smp(n[7:0], 4'b1111);
      if (n == 1) check("fand_pre", 32'(triggered), 0);
      if (n == 2) check("fand_trig", 32'(triggered), 1);
    end
    check("fand_done", 32'(done), 1);
    readout("fand_rd", 0, 1);

    // Empty mask, OR: never fires.
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b1);
    do_arm(4'd0);
    for (int n = 0; n < 100; n++) smp(n[7:0], n[3:0]);
    check("for_state", 32'(state_o), 2);
    check("for_done", 32'(done), 0);
    check("for_trig", 32'(triggered), 0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_wait", 32'(state_o), 0);

    // arm and abort together in IDLE.
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle", 32'(state_o), 0);

    run_t1("armpost", 8);

    // Abort during POST, then a full re-capture.
    cfg(4'b0011, 4'b0001, 4'b0000, 1'b0);
    do_arm(4'd4);
    for (int n = 0; n <= 8; n++) smp(n[7:0], n[3:0]);
    check("abpost_in_post", 32'(state_o), 3);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abpost_state", 32'(state_o), 0);
    check("abpost_done", 32'(done), 0);
    check("abpost_trig", 32'(triggered), 0);
    run_t1("rearm", -1);

    // Decimation: qualified every 3rd cycle; rising edge only between qualified samples 6 and 7.
    cfg(4'b0001, 4'b0001, 4'b0001, 1'b1);
    trig_i = 4'b0000;
    do_arm(4'd0);
    for (int s = 0; s <= 22; s++) begin
      for (int c = 0; c < 3; c++) begin
        int cyc;
        cyc = 3 * s + c;
        data_i = cyc[7:0];
        if (c == 2) begin
          sample_en = 1'b1;
          trig_i    = (s == 6) ? 4'b0000 : 4'b0001;
        end else begin
          sample_en = 1'b0;
          trig_i    = 4'b0000;
        end
        tick();
      end
      sample_en = 1'b0;
      if (s == 6) check("dec_no_early", 32'(triggered), 0);
      if (s == 7) check("dec_trig", 32'(triggered), 1);
    end
    check("dec_done", 32'(done), 1);
    readout("dec_rd", 23, 3);

    // Asynchronous reset in the middle of WAIT.
    cfg(4'b0000, 4'b0000, 4'b0000, 1'b1);
    do_arm(4'd5);
    for (int n = 0; n < 7; n++) smp(n[7:0], 4'b0000);
    check("mrst_pre_state", 32'(state_o), 2);
    check("mrst_pre_taddr", 32'(trig_addr), 5);
    check("mrst_pre_rdata", 32'(rd_data), 68);
    #2;
    clk_rst_n = 1'b0;
    #1;
    check("mrst_state", 32'(state_o), 0);
    check("mrst_trig", 32'(triggered), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_taddr", 32'(trig_addr), 0);
    check("mrst_rdata", 32'(rd_data), 0);
    @(negedge sys_clk);
    clk_rst_n = 1'b1;
    tick();
    check("mrst_after", 32'(state_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised on-chip logic-analyser capture core.
- Successor to the fixed 8-bit, vendor-inserted probe: configurable data and trigger widths, buffer depth, pre-trigger length, per-bit level/edge trigger with AND/OR combine, sample decimation.
- Capture buffer is read back by the host-command path (recv/send data analysers over FT232), not JTAG.
- Sits beside the PLL/clock-reset logic and probes internal nets on sys_clk.

Parameters:
DATA_W, 8, captured sample width
TRIG_W, 32, trigger input width
DEPTH, 1024, samples per capture; power of two, >=4
ADDR_W, $clog2(DEPTH), buffer address width (derived)

Ports:
sys_clk  in  1  capture clock
clk_rst_n  in  1  asynchronous active-low reset
data_i  in  DATA_W  probed data
trig_i  in  TRIG_W  trigger nets
sample_en  in  1  qualifies a sample cycle (decimation); all capture/trigger logic advances only when 1
arm  in  1  single-cycle start pulse
abort  in  1  single-cycle stop pulse
trig_mask  in  TRIG_W  1 = bit participates in trigger
trig_value  in  TRIG_W  level to match, or edge polarity (1 = rising, 0 = falling)
trig_edge_en  in  TRIG_W  1 = edge compare, 0 = level compare
trig_mode  in  1  0 = AND of participating bits, 1 = OR
pretrig_len  in  ADDR_W  samples kept before trigger; latched on arm; clamped to DEPTH-1
rd_en  in  1  read strobe
rd_addr  in  ADDR_W  logical index, 0 = oldest sample
rd_data  out  DATA_W  read data, 1-cycle latency
state_o  out  3  0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
triggered  out  1  trigger seen in current capture
done  out  1  capture complete
trig_addr  out  ADDR_W  logical index of trigger sample (= latched pretrig_len)

Behaviour:
- Reset: state IDLE; write pointer, counters, start pointer, trigger history, triggered, done, trig_addr and rd_data all 0.
- Storage: single dual-port RAM of DEPTH x DATA_W; write port and read port both on sys_clk.
- Sampling rule: the arm cycle itself is never sampled. Each later cycle with sample_en=1 in PRE/WAIT/POST writes data_i at wr_ptr, then wr_ptr increments mod DEPTH.
- IDLE/DONE + arm:
  - wr_ptr=0; latch pretrig_len (clamped); clear triggered, done and the edge-history valid flag.
  - Go to PRE, or directly to WAIT if the latched length is 0.
- PRE: count written samples; after pretrig_len samples go to WAIT. Trigger is not evaluated in PRE.
- WAIT:
  - Evaluate the trigger on every sample; the buffer wraps freely.
  - On hit: this sample is written; start_ptr = (wr_ptr - pretrig_len) mod DEPTH; triggered=1 next cycle; post_cnt = DEPTH-1-pretrig_len.
  - Go to POST, or to DONE if post_cnt = 0.
- POST: each sample decrements post_cnt; after the last one, DONE and done=1 on the following cycle.
- DONE: holds; done and triggered stay 1 until the next arm or abort.
- Trigger per participating bit i:
  - Level: trig_i[i] == trig_value[i].
  - Edge: prev[i] != trig_i[i] and trig_i[i] == trig_value[i].
  - prev is registered on every sample_en in PRE/WAIT/POST. Edge bits are false until prev is valid, i.e. never on the first sample after arm.
- Combine:
  - AND: all participating bits true. trig_mask=0 fires on the first WAIT sample (forced trigger).
  - OR: any participating bit true. trig_mask=0 never fires.
- Read: rd_data <= RAM[(start_ptr + rd_addr) mod DEPTH] one cycle after rd_en; rd_data holds otherwise. Contents are only defined in DONE. Reads are never blocked.
- abort: any state -> IDLE next cycle; clears done and triggered; buffer contents kept.
- Command priority: abort beats arm in the same cycle. arm in PRE/WAIT/POST is ignored.
- Asynchronous reset mid-capture returns everything to the reset values.

Test Plan:
- Level AND, pre-trigger:
  - Setup: DEPTH=16, DATA_W=8, TRIG_W=4; data_i = sample counter starting at 0 after arm; trig_i = data_i[3:0]; mask=0011, value=0001, edge_en=0, pretrig=4.
  - Expect: trigger on sample 5, done after sample 16, trig_addr=4; rd_addr 0..15 returns 1..16.
- Wraparound:
  - Setup: same config, trig_i=0 except bit2 high on sample 40 only; mask=0100, value=0100.
  - Expect: readout 36..51; triggered=1, done=1.
- Falling edge, OR mode, no pre-trigger:
  - Setup: pretrig=0; edge_en=0001, value=0, mask=0001; trig_i[0] low at arm, high on samples 3..8, low at sample 9.
  - Expect: no trigger at the first sample; trigger at 9; readout 9..24; trig_addr=0.
- Empty mask:
  - AND mode, pretrig=2 -> trigger at sample 2, readout 0..15.
  - OR mode -> state stays WAIT for 100 samples, done=0.
- Command collisions:
  - arm pulsed during POST -> ignored, capture completes normally.
  - abort during POST -> IDLE next cycle, done=0; re-arm -> full capture correct.
  - arm and abort in the same cycle in IDLE -> stays IDLE.
- Decimation:
  - Setup: sample_en high every 3rd cycle, data_i = cycle count.
  - Expect: buffer holds only the qualified cycle values, step 3; edge history ignores unqualified cycles.
  - Reset asserted mid-WAIT -> all outputs return to 0 and state_o=0 immediately.
